// File: rtl/mode_input_router_pkg.sv
// mode_input_router shared types and helpers.
// Channel FSM encoding and a constant log2 helper.
package mode_input_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    REPEAT  = 2'd2,
    BLOCKED = 2'd3
  } btn_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mode_input_router_btn_channel.sv
// One push-button channel: 2-FF sync, debounce,
// hold counter and press/long/repeat FSM.
module btn_channel
  import mode_input_router_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic lockout,
  output logic level,
  output logic press,
  output logic long_hit,
  output logic rep_hit
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nx;
  btn_state_t       state;
  btn_state_t       state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      level   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        level   <= ~level;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  // IDLE with level high can only mean a fresh rising edge
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt + 1'b1;
    press    = 1'b0;
    long_hit = 1'b0;
    rep_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        hold_nx = '0;
        if (level) begin
          if (lockout) begin
            state_nx = BLOCKED;
          end else begin
            press    = 1'b1;
            state_nx = HELD;
          end
        end
      end
      HELD: begin
        if (!level) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (hold_cnt == LONG_LAST) begin
          long_hit = 1'b1;
          hold_nx  = '0;
          state_nx = REPEAT;
        end
      end
      REPEAT: begin
        if (!level) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (hold_cnt == REP_LAST) begin
          rep_hit = 1'b1;
          hold_nx = '0;
        end
      end
      BLOCKED: begin
        hold_nx = '0;
        if (!level) state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mode_input_router.sv
// Mode-select debounce/decode, lockout and steering of
// conditioned button events to the active mode slice.
module mode_input_router
  import mode_input_router_pkg::*;
#(
  parameter int NUM_SW        = 4,
  parameter int NUM_MODES     = 4,
  parameter int DEB_CYCLES    = 500000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MODES-1:0]           mode_sel,
  input  logic [NUM_SW-1:0]              sw_in,
  output logic [clog2(NUM_MODES)-1:0]    mode_idx,
  output logic                           mode_change,
  output logic [NUM_MODES*NUM_SW-1:0]    sw_level,
  output logic [NUM_MODES*NUM_SW-1:0]    sw_press,
  output logic [NUM_MODES*NUM_SW-1:0]    sw_long,
  output logic [NUM_MODES*NUM_SW-1:0]    sw_repeat
);

  localparam int IW = clog2(NUM_MODES);
  localparam int OW = NUM_MODES * NUM_SW;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_MODES-1:0] msync1;
  logic [NUM_MODES-1:0] msync2;
  logic [NUM_MODES-1:0] mlvl;
  logic [CNT_W-1:0]     mcnt;
  logic [IW-1:0]        new_idx;
  logic                 maccept;
  logic                 mchg;
  logic                 lockout;
  logic                 lock_eff;

  logic [NUM_SW-1:0] lvl;
  logic [NUM_SW-1:0] prs;
  logic [NUM_SW-1:0] lng;
  logic [NUM_SW-1:0] rpt;

  logic [OW-1:0] level_nx;
  logic [OW-1:0] press_nx;
  logic [OW-1:0] long_nx;
  logic [OW-1:0] rep_nx;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw     (sw_in[i]),
      .lockout (lock_eff),
      .level   (lvl[i]),
      .press   (prs[i]),
      .long_hit(lng[i]),
      .rep_hit (rpt[i])
    );
  end

  always_comb begin
    new_idx = '0;
    for (int m = NUM_MODES - 1; m >= 0; m--)
      if (msync2[m]) new_idx = IW'(m);
  end

  assign maccept  = (msync2 != mlvl) && (mcnt == DEB_LAST);
  assign mchg     = maccept && (new_idx != mode_idx);
  // a mode change in this cycle already blocks a coincident press
  assign lock_eff = lockout | mchg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msync1      <= '0;
      msync2      <= '0;
      mlvl        <= '0;
      mcnt        <= '0;
      mode_idx    <= '0;
      mode_change <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      msync1      <= mode_sel;
      msync2      <= msync1;
      mode_change <= mchg;
      if (msync2 == mlvl) begin
        mcnt <= '0;
      end else if (maccept) begin
        mlvl     <= msync2;
        mcnt     <= '0;
        mode_idx <= new_idx;
      end else begin
        mcnt <= mcnt + 1'b1;
      end
      if (mchg) lockout <= 1'b1;
      else if (lvl == '0) lockout <= 1'b0;
    end
  end

  always_comb begin
    level_nx = '0;
    press_nx = '0;
    long_nx  = '0;
    rep_nx   = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_idx == IW'(m) && !lock_eff) begin
        level_nx[m*NUM_SW +: NUM_SW] = lvl;
        press_nx[m*NUM_SW +: NUM_SW] = prs;
        long_nx[m*NUM_SW +: NUM_SW]  = lng;
        rep_nx[m*NUM_SW +: NUM_SW]   = rpt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_level  <= '0;
      sw_press  <= '0;
      sw_long   <= '0;
      sw_repeat <= '0;
    end else begin
      sw_level  <= level_nx;
      sw_press  <= press_nx;
      sw_long   <= long_nx;
      sw_repeat <= rep_nx;
    end
  end

endmodule

// File: doc/mode_input_router.md
Name: mode_input_router

Overview:
- Parametrised successor to the top-level switch/mode steering in the digital clock.
- Conditions NUM_SW push-button inputs: 2-FF synchronise, debounce, then classify as press, long-press or auto-repeat.
- Steers the resulting registered events to exactly one of NUM_MODES mode blocks, chosen by a synchronised one-hot mode select.
- Replaces per-switch debouncers plus the combinational steering case. Adds lockout on mode change, long-press and auto-repeat, and latch-free outputs.

Parameters:
- NUM_SW, 4, number of push-button channels.
- NUM_MODES, 4, number of mode blocks (width of mode_sel).
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- LONG_CYCLES, 50000000, cycles a debounced press must be held before sw_long fires (1 s).
- REPEAT_CYCLES, 10000000, interval between sw_repeat pulses after sw_long (200 ms).
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, active-low; asserted when 0.
- mode_sel  in  NUM_MODES  raw one-hot mode select (DIP switches).
- sw_in  in  NUM_SW  raw push buttons, 1 = pressed.
- mode_idx  out  $clog2(NUM_MODES)  active mode index.
- mode_change  out  1  one-cycle pulse when mode_idx updates.
- sw_level  out  NUM_MODES*NUM_SW  debounced level; slice [m*NUM_SW +: NUM_SW] belongs to mode m.
- sw_press  out  NUM_MODES*NUM_SW  one-cycle press pulse, same slicing.
- sw_long  out  NUM_MODES*NUM_SW  one-cycle long-press pulse, same slicing.
- sw_repeat  out  NUM_MODES*NUM_SW  one-cycle auto-repeat pulse, same slicing.

Interface note (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: all synchronisers, debounced levels and counters are 0. Channel FSMs are IDLE, mode_idx = 0, lockout = 0. All outputs are 0.
- Synchronisation: every sw_in and mode_sel bit passes through 2 flops.
- Debounce (per channel):
  - A counter increments while the synchronised input differs from the debounced level; it clears on any match (glitch rejection).
  - When the counter reaches DEB_CYCLES-1, the debounced level toggles and the counter clears.
- Mode decode:
  - The synchronised mode_sel is debounced the same way, as one vector that must be stable for DEB_CYCLES.
  - Decode is lowest set bit wins; all-zero selects mode 0.
  - On an update to a different index: mode_change pulses for one cycle and lockout is set.
- Channel FSM states:
  - IDLE: on a debounced rising level, if lockout = 0, pulse press and go to HELD with the hold counter cleared. If lockout = 1, go to BLOCKED.
  - HELD: hold counter increments. At LONG_CYCLES-1, pulse long, clear the counter and go to REPEAT.
  - REPEAT: at REPEAT_CYCLES-1, pulse repeat and clear the counter. Stay in REPEAT.
  - BLOCKED: no pulses.
  - A debounced falling level returns any state to IDLE without a pulse.
- Lockout: clears in the cycle when every debounced channel level is 0. A button held through a mode change therefore generates nothing in the new mode until it is released and pressed again.
- Steering:
  - Outputs are registered. Only slice mode_idx carries level and pulses; all other slices are 0.
  - sw_level in the active slice is masked to 0 while lockout = 1.
- Latency: raw sw_in edge to sw_press = 2 sync + DEB_CYCLES + 1 output register.
- Simultaneous events:
  - Channels are fully independent; several pulses may assert in the same cycle.
  - If a mode change and a press arrive in the same cycle, lockout wins and the press is suppressed.
- Reset mid-press: all state clears immediately. After release of reset, a still-held button is seen as a fresh press after the debounce delay.

Decomposition:
- Shared package: state encoding IDLE/HELD/REPEAT/BLOCKED (2 bits) and a clog2 helper function.
- One natural sub-module, btn_channel: synchroniser, debouncer, hold counter and FSM for one button. It has inputs lockout, outputs level/press/long/repeat, and is instantiated NUM_SW times by a generate loop.
- The top level holds mode-select debounce/decode, lockout and steering.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, NUM_SW=4, NUM_MODES=4):
- Reset release, mode_sel=0001, raise sw_in[1] at cycle 0 and hold -> sw_press bit 1 pulses at cycle 7, sw_long bit 1 at cycle 27, sw_repeat bit 1 at 32, 37, 42; all other bits 0.
- sw_in[0] with 1-cycle glitches every 3 cycles for 30 cycles -> no press, sw_level stays 0.
- mode_sel 0001->0100 -> mode_change pulses once, mode_idx=2; a following press on sw_in[3] appears only at sw_press[11].
- Hold sw_in[2], switch mode 0->1 mid-hold -> no long/repeat in either slice after the switch; after release and re-press, sw_press[6] pulses.
- mode_sel=0110 -> mode_idx=1; mode_sel=0000 -> mode_idx=0.
- Assert rst during REPEAT -> all outputs 0 within the same cycle; after release with the button still held, press pulses 7 cycles later.
